// File: rtl/button_pkg.sv
// Shared event codes, per-button FSM states and timebase helpers for button_event_ctrl.
package button_pkg;

    localparam logic [1:0] EVT_SHORT  = 2'd0;
    localparam logic [1:0] EVT_LONG   = 2'd1;
    localparam logic [1:0] EVT_REPEAT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_e;

    localparam int unsigned MS_PER_S = 1000;

    // Clock cycles per millisecond, clamped so a tiny CLK_FREQ still yields a valid divider.
    function automatic int unsigned ms_prescale(input int unsigned clk_freq);
        return (clk_freq / MS_PER_S > 0) ? clk_freq / MS_PER_S : 1;
    endfunction

endpackage

// File: rtl/button_press_fsm.sv
// Per-button press classifier: SHORT on early release, LONG after the hold threshold,
// then periodic REPEAT until release.
module button_press_fsm
    import button_pkg::*;
#(
    parameter int unsigned LONG_PRESS_MS = 1000,
    parameter int unsigned REPEAT_MS     = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pressed,
    input  logic       released,
    input  logic       ms_tick,
    output logic       emit,
    output logic [1:0] emit_type,
    output logic       held
);

    localparam int unsigned CNT_MAX = (LONG_PRESS_MS > REPEAT_MS) ? LONG_PRESS_MS : REPEAT_MS;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic press, rel, long_hit, rep_hit;

    // A press and release in the same cycle cancel each other out.
    assign press    = pressed & ~released;
    assign rel      = released & ~pressed;
    assign long_hit = ms_tick && (cnt_q == CW'(LONG_PRESS_MS - 1));
    assign rep_hit  = ms_tick && (cnt_q == CW'(REPEAT_MS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end
            end
            ST_HELD: begin
                if (rel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (long_hit) begin
                    state_d = ST_REPEAT;
                    cnt_d   = '0;
                end else if (ms_tick) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (rel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (rep_hit) begin
                    cnt_d = '0;
                end else if (ms_tick) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        emit      = 1'b0;
        emit_type = EVT_SHORT;
        held      = 1'b0;
        unique case (state_q)
            ST_HELD: begin
                held = 1'b1;
                if (rel) begin
                    emit = 1'b1;
                end else if (long_hit) begin
                    emit      = 1'b1;
                    emit_type = EVT_LONG;
                end
            end
            ST_REPEAT: begin
                held = 1'b1;
                if (!rel && rep_hit) begin
                    emit      = 1'b1;
                    emit_type = EVT_REPEAT;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/button_event_ctrl.sv
// Classifies debounced button presses into SHORT/LONG/REPEAT events and queues them
// round-robin into a small FIFO drained by a valid/ready consumer.
module button_event_ctrl
    import button_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 25_000_000,
    parameter int unsigned NUM_BTN       = 4,
    parameter int unsigned LONG_PRESS_MS = 1000,
    parameter int unsigned REPEAT_MS     = 200,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_BTN-1:0]         btn_pressed,
    input  logic [NUM_BTN-1:0]         btn_released,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(NUM_BTN)-1:0] evt_btn,
    output logic [1:0]                 evt_type,
    output logic [NUM_BTN-1:0]         held,
    output logic                       overflow
);

    localparam int unsigned PRESC = ms_prescale(CLK_FREQ);
    localparam int unsigned PCW   = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int unsigned BW    = $clog2(NUM_BTN);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CCW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EW    = BW + 2;

    logic [PCW-1:0] presc_q, presc_d;
    logic           ms_tick;

    logic [NUM_BTN-1:0]      emit;
    logic [NUM_BTN-1:0][1:0] emit_type;

    logic [NUM_BTN-1:0]      pend_valid_q, pend_valid_d;
    logic [NUM_BTN-1:0][1:0] pend_type_q, pend_type_d;
    logic                    ovf_set;
    logic                    overflow_q;

    logic [BW-1:0]      rr_q, rr_d;
    logic [NUM_BTN-1:0] grant;
    logic [BW-1:0]      grant_idx;
    logic [BW-1:0]      cand;
    logic               grant_any;

    logic [EW-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CCW-1:0] count_q, count_d;
    logic [EW-1:0]  head;
    logic           push, pop, can_push;

    assign ms_tick = (presc_q == PCW'(PRESC - 1));
    assign presc_d = ms_tick ? '0 : presc_q + 1'b1;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_press_fsm #(
            .LONG_PRESS_MS (LONG_PRESS_MS),
            .REPEAT_MS     (REPEAT_MS)
        ) u_fsm (
            .clk       (clk),
            .rst       (rst),
            .pressed   (btn_pressed[i]),
            .released  (btn_released[i]),
            .ms_tick   (ms_tick),
            .emit      (emit[i]),
            .emit_type (emit_type[i]),
            .held      (held[i])
        );
    end

    assign evt_valid = (count_q != '0);
    assign pop       = evt_valid && evt_ready;
    assign can_push  = (count_q != CCW'(FIFO_DEPTH)) || pop;
    assign push      = grant_any;
    assign head      = mem_q[rd_ptr_q];
    assign evt_btn   = evt_valid ? head[EW-1:2] : '0;
    assign evt_type  = evt_valid ? head[1:0] : '0;
    assign overflow  = overflow_q;

    // rr_q holds the first index to search, i.e. one past the last grant.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        rr_d      = rr_q;
        for (int unsigned o = 0; o < NUM_BTN; o++) begin
            cand = BW'((32'(rr_q) + o) % NUM_BTN);
            if (!grant_any && can_push && pend_valid_q[cand]) begin
                grant_any   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
        if (grant_any) begin
            rr_d = BW'((32'(grant_idx) + 1) % NUM_BTN);
        end
    end

    // A slot granted this cycle is free to take a new emit on the same edge.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_type_d  = pend_type_q;
        ovf_set      = 1'b0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (grant[i]) begin
                pend_valid_d[i] = 1'b0;
            end
            if (emit[i]) begin
                if (!pend_valid_q[i] || grant[i]) begin
                    pend_valid_d[i] = 1'b1;
                    pend_type_d[i]  = emit_type[i];
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            pend_valid_q <= '0;
            pend_type_q  <= '0;
            overflow_q   <= 1'b0;
            rr_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            presc_q      <= presc_d;
            pend_valid_q <= pend_valid_d;
            pend_type_q  <= pend_type_d;
            overflow_q   <= overflow_q | ovf_set;
            rr_q         <= rr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {grant_idx, pend_type_q[grant_idx]};
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: ms_tick every 4 cycles, LONG at 5 ms, REPEAT every 3 ms.
module tb_button_event_ctrl;
    import button_pkg::*;

    localparam int unsigned CLK_FREQ      = 4000;
    localparam int unsigned NUM_BTN       = 4;
    localparam int unsigned LONG_PRESS_MS = 5;
    localparam int unsigned REPEAT_MS     = 3;
    localparam int unsigned FIFO_DEPTH    = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_BTN-1:0] btn_pressed;
    logic [NUM_BTN-1:0] btn_released;
    logic               evt_valid;
    logic               evt_ready;
    logic [1:0]         evt_btn;
    logic [1:0]         evt_type;
    logic [NUM_BTN-1:0] held;
    logic               overflow;

    int checks   = 0;
    int failures = 0;
    int nev;
    logic exp_v;

    always #5 clk = ~clk;

    button_event_ctrl #(
        .CLK_FREQ      (CLK_FREQ),
        .NUM_BTN       (NUM_BTN),
        .LONG_PRESS_MS (LONG_PRESS_MS),
        .REPEAT_MS     (REPEAT_MS),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_pressed  (btn_pressed),
        .btn_released (btn_released),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_btn      (evt_btn),
        .evt_type     (evt_type),
        .held         (held),
        .overflow     (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge after the reset edge; inputs set now are sampled at the next edge.
    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        btn_pressed  = '0;
        btn_released = '0;
        evt_ready    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        btn_pressed  = '0;
        btn_released = '0;
        evt_ready    = 1'b0;

        // 1. Reset state and a short press on btn0
        do_reset();
        chk("rst_valid", evt_valid, 0);
        chk("rst_held", held, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_btn", evt_btn, 0);
        chk("rst_type", evt_type, 0);
        btn_pressed = 4'b0001;
        step(1);
        btn_pressed = '0;
        chk("t1_held_on", held, 4'b0001);
        step(7);
        chk("t1_held_mid", held, 4'b0001);
        chk("t1_valid_early", evt_valid, 0);
        btn_released = 4'b0001;
        step(1);
        btn_released = '0;
        chk("t1_held_off", held, 0);
        chk("t1_valid_k", evt_valid, 0);
        step(1);
        chk("t1_valid_k1", evt_valid, 1);
        chk("t1_btn", evt_btn, 0);
        chk("t1_type", evt_type, EVT_SHORT);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        chk("t1_drained", evt_valid, 0);
        step(6);
        chk("t1_single", evt_valid, 0);

        // 2. Long hold on btn1 with repeats, consumer always ready
        do_reset();
        evt_ready   = 1'b1;
        btn_pressed = 4'b0010;
        nev = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            btn_pressed  = '0;
            btn_released = (k == 48) ? 4'b0010 : 4'b0000;
            exp_v = (k == 21 || k == 33 || k == 45);
            chk("t2_valid", evt_valid, exp_v);
            if (evt_valid) nev++;
            if (exp_v) begin
                chk("t2_btn", evt_btn, 1);
                chk("t2_type", evt_type, (k == 21) ? EVT_LONG : EVT_REPEAT);
            end
            if (k == 48) chk("t2_held_on", held, 4'b0010);
            if (k == 49) chk("t2_held_off", held, 0);
        end
        chk("t2_count", nev, 3);

        // 3. Simultaneous shorts on all buttons drain in index order
        do_reset();
        evt_ready   = 1'b1;
        btn_pressed = 4'b1111;
        step(1);
        btn_pressed = '0;
        step(1);
        btn_released = 4'b1111;
        step(1);
        btn_released = '0;
        step(1);
        for (int j = 0; j < 4; j++) begin
            chk("t3_valid", evt_valid, 1);
            chk("t3_btn", evt_btn, j);
            chk("t3_type", evt_type, EVT_SHORT);
            step(1);
        end
        chk("t3_empty", evt_valid, 0);
        chk("t3_ovf", overflow, 0);

        // 4. Backpressure: six shorts on btn0, FIFO + pending absorb five
        do_reset();
        for (int i = 0; i < 6; i++) begin
            btn_pressed = 4'b0001;
            step(1);
            btn_pressed = '0;
            step(1);
            btn_released = 4'b0001;
            step(1);
            btn_released = '0;
            chk("t4_ovf", overflow, (i == 5) ? 1 : 0);
            step(1);
        end
        evt_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            chk("t4_valid", evt_valid, 1);
            chk("t4_btn", evt_btn, 0);
            chk("t4_type", evt_type, EVT_SHORT);
            step(1);
        end
        chk("t4_empty", evt_valid, 0);
        step(4);
        chk("t4_empty_late", evt_valid, 0);
        chk("t4_ovf_sticky", overflow, 1);
        evt_ready = 1'b0;

        // 5. Full FIFO with a pending event: one-cycle pop pushes on the same edge
        do_reset();
        btn_pressed = 4'b1111;
        step(1);
        btn_pressed = '0;
        step(1);
        btn_released = 4'b1111;
        step(1);
        btn_released = '0;
        step(5);
        btn_pressed = 4'b0100;
        step(1);
        btn_pressed = '0;
        step(1);
        btn_released = 4'b0100;
        step(1);
        btn_released = '0;
        step(1);
        chk("t5_head0", evt_btn, 0);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        chk("t5_head1", evt_btn, 1);
        step(1);
        chk("t5_hold", evt_btn, 1);
        evt_ready = 1'b1;
        step(1);
        chk("t5_head2", evt_btn, 2);
        step(1);
        chk("t5_head3", evt_btn, 3);
        step(1);
        chk("t5_head_new", evt_btn, 2);
        chk("t5_valid_new", evt_valid, 1);
        step(1);
        chk("t5_empty", evt_valid, 0);
        chk("t5_ovf", overflow, 0);
        evt_ready = 1'b0;

        // 6. Reset while btn2 repeats and the FIFO holds two events
        do_reset();
        btn_pressed = 4'b0100;
        step(1);
        btn_pressed = '0;
        step(33);
        chk("t6_pre_valid", evt_valid, 1);
        chk("t6_pre_btn", evt_btn, 2);
        chk("t6_pre_type", evt_type, EVT_LONG);
        chk("t6_pre_held", held, 4'b0100);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t6_valid", evt_valid, 0);
        chk("t6_held", held, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_btn", evt_btn, 0);
        step(1);
        btn_released = 4'b0100;
        step(1);
        btn_released = '0;
        for (int j = 0; j < 6; j++) begin
            chk("t6_no_evt", evt_valid, 0);
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
